// File: rtl/instr_fetch_seq_if.sv
// Fetch sequencer bus: program load, control and flag inputs,
// issued-instruction and status outputs.
interface instr_fetch_seq_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [31:0]       prog_wdata;
    logic              zf;
    logic              cf;
    logic [31:0]       instruction;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;

    modport master (
        output start, prog_we, prog_addr, prog_wdata, zf, cf,
        input  instruction, pc, busy, halted
    );

    modport slave (
        input  start, prog_we, prog_addr, prog_wdata, zf, cf,
        output instruction, pc, busy, halted
    );
endinterface

// File: rtl/instr_fetch_seq.sv
// Instruction fetch/sequencer: program RAM, PC, and in-fetch resolution
// of JMP/JZ/JC/HALT with a NOP issued in their slot.
module instr_fetch_seq #(
    parameter int         DEPTH   = 256,
    parameter int         ADDR_W  = 8,
    parameter logic [7:0] OP_NOP  = 8'h00,
    parameter logic [7:0] OP_JMP  = 8'hF0,
    parameter logic [7:0] OP_JZ   = 8'hF1,
    parameter logic [7:0] OP_JC   = 8'hF2,
    parameter logic [7:0] OP_HALT = 8'hFF
) (
    input logic               clk,
    input logic               rst,
    instr_fetch_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_BRWAIT,
        S_HALT
    } state_e;

    localparam logic [31:0] NOP_W = {OP_NOP, 24'h0};

    state_e            state_q, state_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;

    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       w;
    logic [7:0]        op;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] tgt;
    logic              idle;
    logic              taken;

    assign w      = mem_q[pc_q];
    assign op     = w[31:24];
    assign tgt    = w[ADDR_W-1:0];
    assign pc_inc = (pc_q == ADDR_W'(DEPTH - 1)) ? '0 : pc_q + ADDR_W'(1);
    assign idle   = (state_q == S_IDLE) || (state_q == S_HALT);
    assign taken  = ((op == OP_JZ) && bus.zf) || ((op == OP_JC) && bus.cf);

    // Loading is only allowed while stopped, so no self-modifying code.
    always_ff @(posedge clk) begin
        if (idle && bus.prog_we) begin
            mem_q[bus.prog_addr] <= bus.prog_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = NOP_W;
        pc_d    = pc_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (bus.start && !bus.prog_we) begin
                    pc_d    = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (op == OP_JMP) begin
                    pc_d = tgt;
                end else if ((op == OP_JZ) || (op == OP_JC)) begin
                    // Wait one slot so the flags of the previous word settle.
                    state_d = S_BRWAIT;
                end else if (op == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    instr_d = w;
                    pc_d    = pc_inc;
                end
            end
            S_BRWAIT: begin
                pc_d    = taken ? tgt : pc_inc;
                state_d = S_RUN;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d   = (state_d == S_RUN) || (state_d == S_BRWAIT);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            instr_q  <= NOP_W;
            pc_q     <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            pc_q     <= pc_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
        end
    end

    assign bus.instruction = instr_q;
    assign bus.pc          = pc_q;
    assign bus.busy        = busy_q;
    assign bus.halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: straight line, JMP, JZ both ways,
// JC, load/start priority, RUN write blocking, PC wrap, async reset.
module tb_instr_fetch_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    instr_fetch_seq_if #(.ADDR_W(8)) bus ();

    instr_fetch_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] a, input logic [31:0] d);
        bus.prog_we    = 1'b1;
        bus.prog_addr  = a;
        bus.prog_wdata = d;
        tick();
        bus.prog_we    = 1'b0;
    endtask

    task automatic go();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    localparam logic [31:0] HLT = 32'hFF00_0000;

    initial begin
        bus.start      = 1'b0;
        bus.prog_we    = 1'b0;
        bus.prog_addr  = '0;
        bus.prog_wdata = '0;
        bus.zf         = 1'b0;
        bus.cf         = 1'b0;
        #1;
        chk("rst_instr", bus.instruction, 32'h0);
        chk("rst_pc", {24'h0, bus.pc}, 32'h0);
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_halted", {31'h0, bus.halted}, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Straight line A,B,C then HALT at 3
        load(8'd0, 32'h1111_0001);
        load(8'd1, 32'h2222_0002);
        load(8'd2, 32'h3333_0003);
        load(8'd3, HLT);
        go();
        chk("sl_busy", {31'h0, bus.busy}, 32'h1);
        chk("sl_pc0", {24'h0, bus.pc}, 32'h0);
        chk("sl_nop0", bus.instruction, 32'h0);
        tick();
        chk("sl_a", bus.instruction, 32'h1111_0001);
        tick();
        chk("sl_b", bus.instruction, 32'h2222_0002);
        tick();
        chk("sl_c", bus.instruction, 32'h3333_0003);
        chk("sl_pc3", {24'h0, bus.pc}, 32'h3);
        tick();
        chk("sl_hnop", bus.instruction, 32'h0);
        chk("sl_halted", {31'h0, bus.halted}, 32'h1);
        chk("sl_hbusy", {31'h0, bus.busy}, 32'h0);
        chk("sl_hpc", {24'h0, bus.pc}, 32'h3);

        // JMP 5
        load(8'd0, 32'hF000_0005);
        load(8'd5, 32'hDDDD_0005);
        load(8'd6, HLT);
        go();
        chk("jmp_pc0", {24'h0, bus.pc}, 32'h0);
        tick();
        chk("jmp_nop", bus.instruction, 32'h0);
        chk("jmp_pc5", {24'h0, bus.pc}, 32'h5);
        tick();
        chk("jmp_d", bus.instruction, 32'hDDDD_0005);
        chk("jmp_pc6", {24'h0, bus.pc}, 32'h6);
        tick();
        chk("jmp_halt", {31'h0, bus.halted}, 32'h1);

        // JZ taken (zf=1) and not taken (zf=0)
        load(8'd0, 32'h4444_0000);
        load(8'd1, 32'hF100_0010);
        load(8'd2, 32'h6666_0002);
        load(8'd3, HLT);
        load(8'd16, 32'h5555_0016);
        load(8'd17, HLT);
        for (int t = 1; t >= 0; t--) begin
            bus.zf = 1'(t);
            go();
            tick();
            chk("jz_sub", bus.instruction, 32'h4444_0000);
            tick();
            chk("jz_nop1", bus.instruction, 32'h0);
            chk("jz_bw_pc", {24'h0, bus.pc}, 32'h1);
            chk("jz_bw_busy", {31'h0, bus.busy}, 32'h1);
            tick();
            chk("jz_nop2", bus.instruction, 32'h0);
            chk("jz_pc", {24'h0, bus.pc}, (t == 1) ? 32'h10 : 32'h2);
            tick();
            chk("jz_next", bus.instruction,
                (t == 1) ? 32'h5555_0016 : 32'h6666_0002);
            tick();
            chk("jz_halt", {31'h0, bus.halted}, 32'h1);
        end
        bus.zf = 1'b0;

        // JC taken with zf=0, cf=1
        load(8'd1, 32'hF200_0010);
        bus.cf = 1'b1;
        go();
        tick();
        tick();
        tick();
        chk("jc_pc", {24'h0, bus.pc}, 32'h10);
        bus.cf = 1'b0;
        tick();
        chk("jc_next", bus.instruction, 32'h5555_0016);
        tick();

        // prog_we beats start in the same cycle
        bus.start = 1'b1;
        load(8'd10, 32'h8888_000A);
        bus.start = 1'b0;
        chk("pri_busy", {31'h0, bus.busy}, 32'h0);
        chk("pri_halted", {31'h0, bus.halted}, 32'h1);
        load(8'd0, 32'hF000_000A);
        load(8'd11, 32'hF000_0014);
        load(8'd20, HLT);
        go();
        // writes during RUN must be dropped
        bus.prog_we    = 1'b1;
        bus.prog_addr  = 8'd20;
        bus.prog_wdata = 32'h9999_0000;
        tick();
        tick();
        chk("pri_x", bus.instruction, 32'h8888_000A);
        tick();
        chk("run_pc20", {24'h0, bus.pc}, 32'h14);
        tick();
        bus.prog_we = 1'b0;
        chk("run_we_instr", bus.instruction, 32'h0);
        chk("run_we_halt", {31'h0, bus.halted}, 32'h1);

        // Wrap at 255 then async reset mid-run
        load(8'd0, 32'hF000_00FF);
        load(8'd255, 32'h7777_00FF);
        go();
        tick();
        chk("wrap_pc255", {24'h0, bus.pc}, 32'hFF);
        tick();
        chk("wrap_w", bus.instruction, 32'h7777_00FF);
        chk("wrap_pc0", {24'h0, bus.pc}, 32'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_instr", bus.instruction, 32'h0);
        chk("arst_busy", {31'h0, bus.busy}, 32'h0);
        chk("arst_pc", {24'h0, bus.pc}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("arst_idle", {31'h0, bus.busy}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
